// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID->EX pipeline register with valid/ready handshake,
// flush, stall and an optional 2-entry skid buffer. With SKID=1 the
// in_ready output comes straight from a flop, so decode never sees a
// combinational path from the execute stage's ready.
module id_ex_pipe_reg #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int CTRL_WIDTH     = 8,
  parameter int SKID           = 1,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_dataA,
  input  logic [DATA_WIDTH-1:0]     in_dataB,
  input  logic [REG_ADDR_WIDTH-1:0] in_wr_addr,
  input  logic [DATA_WIDTH-1:0]     in_pcpp,
  input  logic [DATA_WIDTH-1:0]     in_ext,
  input  logic [CTRL_WIDTH-1:0]     in_ctrl,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_dataA,
  output logic [DATA_WIDTH-1:0]     out_dataB,
  output logic [REG_ADDR_WIDTH-1:0] out_wr_addr,
  output logic [DATA_WIDTH-1:0]     out_pcpp,
  output logic [DATA_WIDTH-1:0]     out_ext,
  output logic [CTRL_WIDTH-1:0]     out_ctrl,
  output logic [CNT_WIDTH-1:0]      bubble_count
);

  // A beat is kept as one packed vector: {A, B, wr_addr, pcpp, ext, ctrl}.
  localparam int BEAT_W  = 4*DATA_WIDTH + REG_ADDR_WIDTH + CTRL_WIDTH;
  localparam int CTRL_LO = 0;
  localparam int EXT_LO  = CTRL_LO + CTRL_WIDTH;
  localparam int PCPP_LO = EXT_LO + DATA_WIDTH;
  localparam int WR_LO   = PCPP_LO + DATA_WIDTH;
  localparam int B_LO    = WR_LO + REG_ADDR_WIDTH;
  localparam int A_LO    = B_LO + DATA_WIDTH;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]           r_state;
  logic                 r_inReady;
  logic [BEAT_W-1:0]    r_main;
  logic [BEAT_W-1:0]    r_skid;
  logic [CNT_WIDTH-1:0] r_bubble;

  logic [BEAT_W-1:0] w_inBeat;
  logic              w_accept;
  logic              w_deliver;
  logic [1:0]        w_nextState;
  logic              w_loadMainIn;
  logic              w_loadMainSkid;
  logic              w_loadSkid;

  assign w_inBeat  = {in_dataA, in_dataB, in_wr_addr, in_pcpp, in_ext, in_ctrl};
  assign out_valid = (r_state != ST_EMPTY);
  assign in_ready  = (SKID != 0) ? r_inReady : ((r_state == ST_EMPTY) | out_ready);
  assign w_accept  = in_valid & in_ready;
  assign w_deliver = out_valid & out_ready;

  assign out_dataA    = r_main[A_LO    +: DATA_WIDTH];
  assign out_dataB    = r_main[B_LO    +: DATA_WIDTH];
  assign out_wr_addr  = r_main[WR_LO   +: REG_ADDR_WIDTH];
  assign out_pcpp     = r_main[PCPP_LO +: DATA_WIDTH];
  assign out_ext      = r_main[EXT_LO  +: DATA_WIDTH];
  assign out_ctrl     = r_main[CTRL_LO +: CTRL_WIDTH];
  assign bubble_count = r_bubble;

  // Occupancy transitions and which register loads what; flush empties everything.
  always_comb begin
    w_nextState    = r_state;
    w_loadMainIn   = 1'b0;
    w_loadMainSkid = 1'b0;
    w_loadSkid     = 1'b0;
    if (flush) begin
      w_nextState = ST_EMPTY;
    end else if (SKID != 0) begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_loadMainIn = 1'b1;
            w_nextState  = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_accept && w_deliver) begin
            w_loadMainIn = 1'b1;
          end else if (w_accept) begin
            w_loadSkid  = 1'b1;
            w_nextState = ST_TWO;
          end else if (w_deliver) begin
            w_nextState = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_deliver) begin
            w_loadMainSkid = 1'b1;
            w_nextState    = ST_ONE;
          end
        end
        default: w_nextState = ST_EMPTY;
      endcase
    end else begin
      if (w_accept) begin
        w_loadMainIn = 1'b1;
        w_nextState  = ST_ONE;
      end else if (w_deliver) begin
        w_nextState = ST_EMPTY;
      end
    end
  end

  // Control state; in_ready is precomputed from the next state so it leaves a flop.
  always_ff @(negedge clock) begin
    if (reset) begin
      r_state   <= ST_EMPTY;
      r_inReady <= 1'b1;
    end else begin
      r_state   <= w_nextState;
      r_inReady <= (w_nextState != ST_TWO);
    end
  end

  // Beat storage; the main register keeps its contents when emptied so outputs hold.
  always_ff @(negedge clock) begin
    if (reset) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_loadMainIn) begin
        r_main <= w_inBeat;
      end else if (w_loadMainSkid) begin
        r_main <= r_skid;
      end
      if (w_loadSkid) begin
        r_skid <= w_inBeat;
      end
    end
  end

  // Saturating count of edges where execute was ready but had nothing to take.
  always_ff @(negedge clock) begin
    if (reset) begin
      r_bubble <= '0;
    end else if (out_ready && !out_valid && (r_bubble != {CNT_WIDTH{1'b1}})) begin
      r_bubble <= r_bubble + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb_id_ex_pipe_reg: drives a SKID=1 and a SKID=0 instance from the same
// stimulus and compares both against a queue-style reference model every
// cycle, with a few directed scenarios pinned by literal expectations.
module tb_id_ex_pipe_reg;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  w;
    logic [31:0] p;
    logic [31:0] e;
    logic [7:0]  c;
  } beat_t;

  logic  clock;
  logic  reset;
  logic  flush;
  logic  in_valid;
  logic  out_ready;
  beat_t inBeat;

  logic        inReady[2];
  logic        outValid[2];
  logic [31:0] outA[2];
  logic [31:0] outB[2];
  logic [3:0]  outW[2];
  logic [31:0] outP[2];
  logic [31:0] outE[2];
  logic [7:0]  outC[2];
  logic [15:0] bub[2];

  // Reference model: index 1 = skid version (capacity 2), index 0 = single entry.
  beat_t       mBuf[2][2];
  int          mCnt[2];
  beat_t       mShown[2];
  logic [15:0] mBub[2];

  int compared   = 0;
  int mismatched = 0;

  id_ex_pipe_reg #(.SKID(1)) dut1 (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(inReady[1]),
    .in_dataA(inBeat.a), .in_dataB(inBeat.b), .in_wr_addr(inBeat.w),
    .in_pcpp(inBeat.p), .in_ext(inBeat.e), .in_ctrl(inBeat.c),
    .out_valid(outValid[1]), .out_ready(out_ready),
    .out_dataA(outA[1]), .out_dataB(outB[1]), .out_wr_addr(outW[1]),
    .out_pcpp(outP[1]), .out_ext(outE[1]), .out_ctrl(outC[1]),
    .bubble_count(bub[1])
  );

  id_ex_pipe_reg #(.SKID(0)) dut0 (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(inReady[0]),
    .in_dataA(inBeat.a), .in_dataB(inBeat.b), .in_wr_addr(inBeat.w),
    .in_pcpp(inBeat.p), .in_ext(inBeat.e), .in_ctrl(inBeat.c),
    .out_valid(outValid[0]), .out_ready(out_ready),
    .out_dataA(outA[0]), .out_dataB(outB[0]), .out_wr_addr(outW[0]),
    .out_pcpp(outP[0]), .out_ext(outE[0]), .out_ctrl(outC[0]),
    .bubble_count(bub[0])
  );

  // Free-running clock; the design updates on the falling edge.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic bit modelReady(input int k);
    if (k == 1) return (mCnt[1] < 2);
    return (mCnt[0] == 0) || out_ready;
  endfunction

  function automatic beat_t mkBeat(input logic [31:0] a, input logic [3:0] w);
    beat_t bt;
    bt.a = a;
    bt.b = ~a;
    bt.w = w;
    bt.p = a + 32'd1;
    bt.e = a << 2;
    bt.c = a[7:0] ^ 8'h5A;
    return bt;
  endfunction

  function automatic beat_t randBeat();
    beat_t bt;
    bt.a = $urandom;
    bt.b = $urandom;
    bt.w = 4'($urandom_range(0, 15));
    bt.p = $urandom;
    bt.e = $urandom;
    bt.c = 8'($urandom_range(0, 255));
    return bt;
  endfunction

  task automatic checkOutput();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("k%0d out_valid", k), 64'(outValid[k]), 64'(mCnt[k] > 0));
      check($sformatf("k%0d in_ready", k), 64'(inReady[k]), 64'(modelReady(k)));
      check($sformatf("k%0d out_dataA", k), 64'(outA[k]), 64'(mShown[k].a));
      check($sformatf("k%0d out_dataB", k), 64'(outB[k]), 64'(mShown[k].b));
      check($sformatf("k%0d out_wr_addr", k), 64'(outW[k]), 64'(mShown[k].w));
      check($sformatf("k%0d out_pcpp", k), 64'(outP[k]), 64'(mShown[k].p));
      check($sformatf("k%0d out_ext", k), 64'(outE[k]), 64'(mShown[k].e));
      check($sformatf("k%0d out_ctrl", k), 64'(outC[k]), 64'(mShown[k].c));
      check($sformatf("k%0d bubble_count", k), 64'(bub[k]), 64'(mBub[k]));
    end
  endtask

  // Advance the model by one falling edge using the inputs currently driven.
  task automatic modelUpdate();
    bit rdy;
    bit acc;
    bit del;
    for (int k = 0; k < 2; k++) begin
      rdy = modelReady(k);
      if (reset) begin
        mCnt[k]   = 0;
        mShown[k] = '0;
        mBub[k]   = '0;
      end else begin
        if (out_ready && mCnt[k] == 0 && mBub[k] != 16'hFFFF) mBub[k] = mBub[k] + 16'd1;
        if (flush) begin
          mCnt[k] = 0;
        end else begin
          acc = in_valid && rdy;
          del = out_ready && (mCnt[k] > 0);
          if (del) begin
            mBuf[k][0] = mBuf[k][1];
            mCnt[k]--;
          end
          if (acc) begin
            mBuf[k][mCnt[k]] = inBeat;
            mCnt[k]++;
          end
          if (mCnt[k] > 0) mShown[k] = mBuf[k][0];
        end
      end
    end
  endtask

  // Drive one cycle of inputs, compare the pre-edge outputs, then step the model.
  task automatic applyStimulus(input bit rst, input bit fl, input bit iv, input beat_t bt, input bit ordy);
    @(posedge clock);
    reset     = rst;
    flush     = fl;
    in_valid  = iv;
    inBeat    = bt;
    out_ready = ordy;
    #1;
    checkOutput();
    modelUpdate();
  endtask

  task automatic settle();
    @(negedge clock);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    inBeat    = '0;
    for (int k = 0; k < 2; k++) begin
      mCnt[k]   = 0;
      mShown[k] = '0;
      mBub[k]   = '0;
    end
    settle();

    // Reset state
    applyStimulus(1, 0, 0, '0, 0);
    settle();
    check("reset out_valid", 64'(outValid[1]), 64'd0);
    check("reset in_ready", 64'(inReady[1]), 64'd1);
    check("reset out_dataA", 64'(outA[1]), 64'd0);
    check("reset bubble", 64'(bub[1]), 64'd0);

    // Five idle edges with execute ready
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, '0, 1);
    settle();
    check("bubble after 5 idle", 64'(bub[1]), 64'd5);
    check("bubble after 5 idle k0", 64'(bub[0]), 64'd5);

    // Single beat latency
    applyStimulus(1, 0, 0, '0, 0);
    applyStimulus(0, 0, 1, mkBeat(32'h11, 4'h3), 1);
    settle();
    check("first beat out_valid", 64'(outValid[1]), 64'd1);
    check("first beat out_dataA", 64'(outA[1]), 64'h11);
    check("first beat out_wr_addr", 64'(outW[1]), 64'h3);
    applyStimulus(0, 0, 0, '0, 1);

    // Fill the skid buffer while stalled, then drain in order
    applyStimulus(0, 0, 1, mkBeat(32'h1, 4'h1), 0);
    applyStimulus(0, 0, 1, mkBeat(32'h2, 4'h2), 0);
    settle();
    check("stall full in_ready", 64'(inReady[1]), 64'd0);
    check("stall full out_dataA", 64'(outA[1]), 64'h1);
    applyStimulus(0, 0, 1, mkBeat(32'h3, 4'h3), 0);
    settle();
    check("stall third held out_dataA", 64'(outA[1]), 64'h1);
    applyStimulus(0, 0, 1, mkBeat(32'h3, 4'h3), 1);
    settle();
    check("drain second out_dataA", 64'(outA[1]), 64'h2);
    check("drain second in_ready", 64'(inReady[1]), 64'd1);
    applyStimulus(0, 0, 1, mkBeat(32'h3, 4'h3), 1);
    settle();
    check("drain third out_dataA", 64'(outA[1]), 64'h3);
    applyStimulus(0, 0, 0, '0, 1);
    settle();
    check("drained out_valid", 64'(outValid[1]), 64'd0);
    check("drained holds out_dataA", 64'(outA[1]), 64'h3);

    // Flush while two beats are held, with a beat offered
    applyStimulus(0, 0, 1, mkBeat(32'h21, 4'h5), 0);
    applyStimulus(0, 0, 1, mkBeat(32'h22, 4'h6), 0);
    applyStimulus(0, 1, 1, mkBeat(32'h99, 4'h9), 0);
    settle();
    check("flush out_valid", 64'(outValid[1]), 64'd0);
    check("flush in_ready", 64'(inReady[1]), 64'd1);
    check("flush holds out_dataA", 64'(outA[1]), 64'h21);
    applyStimulus(0, 0, 0, '0, 1);

    // Reset while two beats are held, with a beat offered
    applyStimulus(0, 0, 1, mkBeat(32'h31, 4'h7), 0);
    applyStimulus(0, 0, 1, mkBeat(32'h32, 4'h8), 0);
    applyStimulus(1, 0, 1, mkBeat(32'h33, 4'hA), 1);
    settle();
    check("midreset out_valid", 64'(outValid[1]), 64'd0);
    check("midreset out_dataA", 64'(outA[1]), 64'd0);
    check("midreset out_wr_addr", 64'(outW[1]), 64'd0);
    check("midreset bubble", 64'(bub[1]), 64'd0);
    check("midreset in_ready", 64'(inReady[1]), 64'd1);

    // Single-entry variant replaces its beat when delivering and accepting together
    applyStimulus(0, 0, 1, mkBeat(32'h41, 4'h1), 0);
    applyStimulus(0, 0, 1, mkBeat(32'h42, 4'h2), 1);
    check("noskid same-cycle in_ready", 64'(inReady[0]), 64'd1);
    settle();
    check("noskid replace out_valid", 64'(outValid[0]), 64'd1);
    check("noskid replace out_dataA", 64'(outA[0]), 64'h42);
    applyStimulus(0, 0, 0, '0, 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
                    ($urandom_range(0, 9) < 6), randBeat(), ($urandom_range(0, 9) < 6));
    end

    // Saturation of the bubble counter
    applyStimulus(1, 0, 0, '0, 0);
    for (int i = 0; i < 65538; i++) applyStimulus(0, 0, 0, '0, 1);
    settle();
    check("bubble saturated", 64'(bub[1]), 64'hFFFF);
    check("bubble saturated k0", 64'(bub[0]), 64'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
